// File: rtl/neopixel_pkg.sv
// Shared definitions for the WS2812 (NeoPixel) serial transmitter.
//   state_e       : transmitter FSM states
//   *Default      : default timing in ACLK cycles, assuming a 100 MHz clock
//   PixW          : width of one GRB pixel word
package neopixel_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StHigh,
    StLow,
    StLatch
  } state_e;

  localparam int unsigned TBitDefault = 125;   // 1.25 us bit period
  localparam int unsigned T0hDefault  = 40;    // '0' high time
  localparam int unsigned T1hDefault  = 80;    // '1' high time
  localparam int unsigned TRstDefault = 5000;  // 50 us end-of-frame latch

  localparam int unsigned PixW = 24;

endpackage

// File: rtl/neopixel_if.sv
// Pixel stream interface between the register stage and the transmitter.
//   pix_data  : GRB pixel word, bit 23 is G7
//   pix_last  : marks the final pixel of a frame
//   pix_valid : upstream word valid
//   pix_ready : transmitter accepts a word this cycle
// master = upstream producer, slave = neopixel_tx.
interface neopixel_if;
  import neopixel_pkg::*;

  logic [PixW-1:0] pix_data;
  logic            pix_last;
  logic            pix_valid;
  logic            pix_ready;

  modport master (
    output pix_data,
    output pix_last,
    output pix_valid,
    input  pix_ready
  );

  modport slave (
    input  pix_data,
    input  pix_last,
    input  pix_valid,
    output pix_ready
  );

endinterface

// File: rtl/neopixel_tx.sv
// WS2812 serial transmitter. Shifts out 24-bit GRB words MSB first, each bit
// one T_BIT period with a T1H ('1') or T0H ('0') high phase, and closes a
// frame with a T_RST low latch period.
//   ACLK      : clock, rising edge
//   ARESET    : synchronous active-high reset
//   pix       : pixel stream (slave side of neopixel_if)
//   dout      : serial line to the LED chain
//   busy      : high in every state except idle
//   underrun  : one-cycle pulse when the next pixel of a frame is missing
// All outputs are registered; next-state values of the outputs are derived
// from the next-state FSM values so they line up with the state they belong to.
module neopixel_tx
  import neopixel_pkg::*;
#(
  parameter int unsigned T_BIT = TBitDefault,
  parameter int unsigned T0H   = T0hDefault,
  parameter int unsigned T1H   = T1hDefault,
  parameter int unsigned T_RST = TRstDefault
) (
  input  logic     ACLK,
  input  logic     ARESET,
  neopixel_if.slave pix,
  output logic     dout,
  output logic     busy,
  output logic     underrun
);

  if (!(T0H > 0 && T0H < T1H && T1H < T_BIT && T_RST > 0)) begin : g_bad_timing
    $error("neopixel_tx: timing requires 0 < T0H < T1H < T_BIT and T_RST > 0");
  end

  localparam int unsigned CntMax = (T_BIT > T_RST) ? T_BIT : T_RST;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  typedef logic [CntW-1:0] cnt_t;

  // Terminal counts: the counter restarts at 0 on every state entry.
  localparam cnt_t HiOneEnd  = cnt_t'(T1H - 1);
  localparam cnt_t HiZeroEnd = cnt_t'(T0H - 1);
  localparam cnt_t LoOneEnd  = cnt_t'(T_BIT - T1H - 1);
  localparam cnt_t LoZeroEnd = cnt_t'(T_BIT - T0H - 1);
  localparam cnt_t LatchEnd  = cnt_t'(T_RST - 1);

  state_e          state_q, state_d;
  cnt_t            cnt_q, cnt_d;
  logic [4:0]      bit_idx_q, bit_idx_d;
  logic [PixW-1:0] sreg_q, sreg_d;
  logic            last_q, last_d;
  logic            dout_q, dout_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic            underrun_q, underrun_d;

  logic xfer;
  logic cur_bit, hi_end, lo_end;
  logic nxt_bit;
  cnt_t nxt_lo_end;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + cnt_t'(1);
    bit_idx_d  = bit_idx_q;
    sreg_d     = sreg_q;
    last_d     = last_q;
    underrun_d = 1'b0;

    xfer    = pix.pix_valid & ready_q;
    cur_bit = sreg_q[bit_idx_q];
    hi_end  = cur_bit ? (cnt_q == HiOneEnd) : (cnt_q == HiZeroEnd);
    lo_end  = cur_bit ? (cnt_q == LoOneEnd) : (cnt_q == LoZeroEnd);

    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (xfer) begin
          state_d   = StHigh;
          bit_idx_d = 5'd23;
          sreg_d    = pix.pix_data;
          last_d    = pix.pix_last;
        end
      end
      StHigh: begin
        if (hi_end) begin
          state_d = StLow;
          cnt_d   = '0;
        end
      end
      StLow: begin
        if (lo_end) begin
          cnt_d = '0;
          if (bit_idx_q != 5'd0) begin
            state_d   = StHigh;
            bit_idx_d = bit_idx_q - 5'd1;
          end else if (xfer) begin
            // Next pixel of the frame follows with no gap.
            state_d   = StHigh;
            bit_idx_d = 5'd23;
            sreg_d    = pix.pix_data;
            last_d    = pix.pix_last;
          end else begin
            state_d    = StLatch;
            underrun_d = ~last_q;
          end
        end
      end
      StLatch: begin
        if (cnt_q == LatchEnd) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    // Ready is offered only on the final LOW cycle of bit 0 of a non-last word,
    // so look ahead at where the counter will be next cycle.
    nxt_bit    = sreg_d[bit_idx_d];
    nxt_lo_end = nxt_bit ? LoOneEnd : LoZeroEnd;
    dout_d     = (state_d == StHigh);
    busy_d     = (state_d != StIdle);
    ready_d    = (state_d == StIdle) ||
                 ((state_d == StLow) && (bit_idx_d == 5'd0) && !last_d &&
                  (cnt_d == nxt_lo_end));
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      sreg_q     <= '0;
      last_q     <= 1'b0;
      dout_q     <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      sreg_q     <= sreg_d;
      last_q     <= last_d;
      dout_q     <= dout_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      underrun_q <= underrun_d;
    end
  end

  assign dout          = dout_q;
  assign busy          = busy_q;
  assign underrun      = underrun_q;
  assign pix.pix_ready = ready_q;

endmodule

// File: tb/tb_neopixel_tx.sv
// Bench for neopixel_tx: one instance with default timing, one with short
// timing. Expected high times are queued when a pixel is driven and popped as
// the serial line produces each bit.
module tb_neopixel_tx;
  import neopixel_pkg::*;

  localparam int SB = 10;
  localparam int S0 = 3;
  localparam int S1 = 7;
  localparam int SR = 20;
  localparam int DB = int'(TBitDefault);
  localparam int D0 = int'(T0hDefault);
  localparam int D1 = int'(T1hDefault);
  localparam int DR = int'(TRstDefault);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  neopixel_if pif ();
  neopixel_if pif_s ();
  logic dout, busy, underrun;
  logic dout_s, busy_s, underrun_s;

  neopixel_tx dut (
    .ACLK    (clk),
    .ARESET  (rst),
    .pix     (pif),
    .dout    (dout),
    .busy    (busy),
    .underrun(underrun)
  );

  neopixel_tx #(
    .T_BIT(SB),
    .T0H  (S0),
    .T1H  (S1),
    .T_RST(SR)
  ) dut_s (
    .ACLK    (clk),
    .ARESET  (rst),
    .pix     (pif_s),
    .dout    (dout_s),
    .busy    (busy_s),
    .underrun(underrun_s)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int under_cnt = 0;
  int under_t   = 0;
  always @(negedge clk) begin
    if (underrun === 1'b1) begin
      under_cnt <= under_cnt + 1;
      under_t   <= cyc;
    end
  end

  int n_vec = 0;
  int n_err = 0;
  int exp_hi_q[$];
  int rise_t[$];
  int fall_t[$];
  bit glitch;

  // which: 0 dout, 1 busy, 2 pix_ready
  function automatic logic sig_of(input bit sel, input int which);
    logic r;
    case (which)
      0:       r = sel ? dout_s : dout;
      1:       r = sel ? busy_s : busy;
      default: r = sel ? pif_s.pix_ready : pif.pix_ready;
    endcase
    return r;
  endfunction

  task automatic wait_level(input bit sel, input int which, input logic lvl, input int budget,
                            output int t, output bit ok);
    ok = 1'b0;
    t  = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (which != 0 && sig_of(sel, 0) === 1'b1) glitch = 1'b1;
      if (sig_of(sel, which) === lvl) begin
        ok = 1'b1;
        t  = cyc;
        break;
      end
    end
  endtask

  task automatic collect_bits(input bit sel, input int n, input int budget, output bit ok);
    int t;
    bit k;
    rise_t.delete();
    fall_t.delete();
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      wait_level(sel, 0, 1'b1, budget, t, k);
      if (!k) begin ok = 1'b0; break; end
      rise_t.push_back(t);
      wait_level(sel, 0, 1'b0, budget, t, k);
      if (!k) begin ok = 1'b0; break; end
      fall_t.push_back(t);
    end
  endtask

  // Call at a negedge. Returns after the accepting edge, at the next negedge.
  task automatic send_pixel(input bit sel, input logic [23:0] data, input logic last,
                            input int budget, output int acc, output bit ok);
    for (int b = 23; b >= 0; b--)
      exp_hi_q.push_back(data[b] ? (sel ? S1 : D1) : (sel ? S0 : D0));
    if (sel) begin
      pif_s.pix_data = data; pif_s.pix_last = last; pif_s.pix_valid = 1'b1;
    end else begin
      pif.pix_data = data; pif.pix_last = last; pif.pix_valid = 1'b1;
    end
    ok  = 1'b0;
    acc = 0;
    for (int i = 0; i < budget; i++) begin
      if (sig_of(sel, 2) === 1'b1) begin
        acc = cyc;
        ok  = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int acc, highs;
    bit ok;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++; if (dout !== 1'b0) begin n_err++; $display("FAIL rst_dout: got %b want 0", dout); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_vec++; if (pif.pix_ready !== 1'b0) begin n_err++;
      $display("FAIL rst_ready: got %b want 0", pif.pix_ready); end
    n_vec++; if (underrun !== 1'b0) begin n_err++;
      $display("FAIL rst_underrun: got %b want 0", underrun); end
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if (pif.pix_ready !== 1'b1) begin n_err++;
      $display("FAIL release_ready: got %b want 1", pif.pix_ready); end
    // Start a frame and reset in the middle of the first bit's high phase.
    send_pixel(1'b0, 24'hAA0055, 1'b1, 10, acc, ok);
    pif.pix_valid = 1'b0;
    n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL rst_accept: got %b want 1", ok); end
    repeat (59) @(negedge clk);
    n_vec++; if (dout !== 1'b1) begin n_err++; $display("FAIL midbit_dout: got %b want 1", dout); end
    rst = 1'b1;
    @(negedge clk);
    n_vec++; if (dout !== 1'b0) begin n_err++; $display("FAIL abort_dout: got %b want 0", dout); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", busy); end
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if (pif.pix_ready !== 1'b1) begin n_err++;
      $display("FAIL abort_release_ready: got %b want 1", pif.pix_ready); end
    highs = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (dout !== 1'b0 || busy !== 1'b0) highs++;
    end
    n_vec++; if (highs !== 0) begin n_err++;
      $display("FAIL abort_quiet: got %0d active cycles want 0", highs); end
    exp_hi_q.delete();
  endtask

  task automatic test_single();
    int acc, tb, e, f, u0;
    bit ok_s, ok_c, ok_b;
    exp_hi_q.delete();
    u0 = under_cnt;
    fork
      begin
        send_pixel(1'b0, 24'hAA0055, 1'b1, 20, acc, ok_s);
        pif.pix_valid = 1'b0;
      end
      collect_bits(1'b0, 24, 400, ok_c);
    join
    n_vec++; if (ok_s !== 1'b1 || ok_c !== 1'b1) begin n_err++;
      $display("FAIL single_bits: got accept=%b collect=%b want 1/1", ok_s, ok_c); end
    n_vec++; if (rise_t.size() == 0 || rise_t[0] !== acc + 1) begin n_err++;
      $display("FAIL single_latency: got rise=%0d want %0d", rise_t.size() ? rise_t[0] : -1,
               acc + 1); end
    foreach (fall_t[i]) begin
      e = exp_hi_q.pop_front();
      n_vec++; if (fall_t[i] - rise_t[i] !== e) begin n_err++;
        $display("FAIL single_high bit%0d: got %0d want %0d", 23 - i, fall_t[i] - rise_t[i], e); end
    end
    for (int i = 1; i < rise_t.size(); i++) begin
      n_vec++; if (rise_t[i] - rise_t[i-1] !== DB) begin n_err++;
        $display("FAIL single_period bit%0d: got %0d want %0d", 24 - i,
                 rise_t[i] - rise_t[i-1], DB); end
    end
    f = fall_t.size() ? fall_t[fall_t.size()-1] : 0;
    glitch = 1'b0;
    wait_level(1'b0, 1, 1'b0, 6000, tb, ok_b);
    n_vec++; if (ok_b !== 1'b1 || tb - f !== (DB - D1) + DR) begin n_err++;
      $display("FAIL single_latch: got %0d want %0d", tb - f, (DB - D1) + DR); end
    n_vec++; if (glitch !== 1'b0) begin n_err++; $display("FAIL single_latch_low: got dout high"); end
    n_vec++; if (under_cnt - u0 !== 0) begin n_err++;
      $display("FAIL single_underrun: got %0d pulses want 0", under_cnt - u0); end
    n_vec++; if (exp_hi_q.size() !== 0) begin n_err++;
      $display("FAIL single_leftover: got %0d want 0", exp_hi_q.size()); end
  endtask

  task automatic test_back_to_back();
    int acc1, acc2, tb, e, f;
    bit ok1, ok2, ok_c, ok_b;
    exp_hi_q.delete();
    fork
      begin
        send_pixel(1'b0, 24'hFFFFFF, 1'b0, 20, acc1, ok1);
        send_pixel(1'b0, 24'h000000, 1'b1, 3500, acc2, ok2);
        pif.pix_valid = 1'b0;
      end
      collect_bits(1'b0, 48, 400, ok_c);
    join
    n_vec++; if (ok1 !== 1'b1 || ok2 !== 1'b1 || ok_c !== 1'b1) begin n_err++;
      $display("FAIL b2b_bits: got %b%b%b want 111", ok1, ok2, ok_c); end
    foreach (fall_t[i]) begin
      e = exp_hi_q.pop_front();
      n_vec++; if (fall_t[i] - rise_t[i] !== e) begin n_err++;
        $display("FAIL b2b_high idx%0d: got %0d want %0d", i, fall_t[i] - rise_t[i], e); end
    end
    for (int i = 1; i < rise_t.size(); i++) begin
      n_vec++; if (rise_t[i] - rise_t[i-1] !== DB) begin n_err++;
        $display("FAIL %s idx%0d: got %0d want %0d", (i == 24) ? "b2b_gap" : "b2b_period", i,
                 rise_t[i] - rise_t[i-1], DB); end
    end
    f = fall_t.size() ? fall_t[fall_t.size()-1] : 0;
    wait_level(1'b0, 1, 1'b0, 6000, tb, ok_b);
    n_vec++; if (ok_b !== 1'b1 || tb - f !== (DB - D0) + DR) begin n_err++;
      $display("FAIL b2b_latch: got %0d want %0d", tb - f, (DB - D0) + DR); end
  endtask

  task automatic test_underrun();
    int acc, tb, e, f, u0;
    bit ok_s, ok_c, ok_b;
    exp_hi_q.delete();
    u0 = under_cnt;
    fork
      begin
        send_pixel(1'b0, 24'h123456, 1'b0, 20, acc, ok_s);
        pif.pix_valid = 1'b0;
      end
      collect_bits(1'b0, 24, 400, ok_c);
    join
    n_vec++; if (ok_s !== 1'b1 || ok_c !== 1'b1) begin n_err++;
      $display("FAIL ur_bits: got %b%b want 11", ok_s, ok_c); end
    foreach (fall_t[i]) begin
      e = exp_hi_q.pop_front();
      n_vec++; if (fall_t[i] - rise_t[i] !== e) begin n_err++;
        $display("FAIL ur_high bit%0d: got %0d want %0d", 23 - i, fall_t[i] - rise_t[i], e); end
    end
    f = fall_t.size() ? fall_t[fall_t.size()-1] : 0;
    glitch = 1'b0;
    wait_level(1'b0, 1, 1'b0, 6000, tb, ok_b);
    n_vec++; if (under_cnt - u0 !== 1) begin n_err++;
      $display("FAIL ur_pulses: got %0d want 1", under_cnt - u0); end
    n_vec++; if (under_t - f !== DB - D0) begin n_err++;
      $display("FAIL ur_time: got %0d want %0d", under_t - f, DB - D0); end
    n_vec++; if (ok_b !== 1'b1 || tb - f !== (DB - D0) + DR) begin n_err++;
      $display("FAIL ur_latch: got %0d want %0d", tb - f, (DB - D0) + DR); end
    n_vec++; if (glitch !== 1'b0) begin n_err++; $display("FAIL ur_latch_low: got dout high"); end
  endtask

  task automatic test_hold_bit12();
    int acc1, acc2, tb, e, f;
    bit ok1, ok2, ok_c, ok_b;
    exp_hi_q.delete();
    fork
      begin
        send_pixel(1'b0, 24'hA5C3F0, 1'b0, 20, acc1, ok1);
        pif.pix_valid = 1'b0;
        repeat (11 * DB + 5) @(negedge clk);
        n_vec++; if (dout !== 1'b1) begin n_err++;
          $display("FAIL hold_in_bit12: got %b want 1", dout); end
        send_pixel(1'b0, 24'h3C0F81, 1'b1, 3000, acc2, ok2);
        pif.pix_valid = 1'b0;
      end
      collect_bits(1'b0, 48, 400, ok_c);
    join
    n_vec++; if (ok1 !== 1'b1 || ok2 !== 1'b1 || ok_c !== 1'b1) begin n_err++;
      $display("FAIL hold_bits: got %b%b%b want 111", ok1, ok2, ok_c); end
    n_vec++; if (acc2 - acc1 !== 24 * DB) begin n_err++;
      $display("FAIL hold_accept: got %0d want %0d", acc2 - acc1, 24 * DB); end
    foreach (fall_t[i]) begin
      e = exp_hi_q.pop_front();
      n_vec++; if (fall_t[i] - rise_t[i] !== e) begin n_err++;
        $display("FAIL hold_high idx%0d: got %0d want %0d", i, fall_t[i] - rise_t[i], e); end
    end
    for (int i = 1; i < rise_t.size(); i++) begin
      n_vec++; if (rise_t[i] - rise_t[i-1] !== DB) begin n_err++;
        $display("FAIL hold_period idx%0d: got %0d want %0d", i, rise_t[i] - rise_t[i-1], DB); end
    end
    f = fall_t.size() ? fall_t[fall_t.size()-1] : 0;
    wait_level(1'b0, 1, 1'b0, 6000, tb, ok_b);
    n_vec++; if (ok_b !== 1'b1 || tb - f !== (DB - D1) + DR) begin n_err++;
      $display("FAIL hold_latch: got %0d want %0d", tb - f, (DB - D1) + DR); end
  endtask

  task automatic test_small_params();
    int acc, tb, e, f;
    bit ok_s, ok_c, ok_b;
    exp_hi_q.delete();
    fork
      begin
        send_pixel(1'b1, 24'h800001, 1'b1, 20, acc, ok_s);
        pif_s.pix_valid = 1'b0;
      end
      collect_bits(1'b1, 24, 50, ok_c);
    join
    n_vec++; if (ok_s !== 1'b1 || ok_c !== 1'b1) begin n_err++;
      $display("FAIL small_bits: got %b%b want 11", ok_s, ok_c); end
    n_vec++; if (rise_t.size() == 0 || rise_t[0] !== acc + 1) begin n_err++;
      $display("FAIL small_latency: got %0d want %0d", rise_t.size() ? rise_t[0] : -1, acc + 1); end
    foreach (fall_t[i]) begin
      e = exp_hi_q.pop_front();
      n_vec++; if (fall_t[i] - rise_t[i] !== e) begin n_err++;
        $display("FAIL small_high bit%0d: got %0d want %0d", 23 - i, fall_t[i] - rise_t[i], e); end
    end
    for (int i = 1; i < rise_t.size(); i++) begin
      n_vec++; if (rise_t[i] - rise_t[i-1] !== SB) begin n_err++;
        $display("FAIL small_period bit%0d: got %0d want %0d", 24 - i, rise_t[i] - rise_t[i-1], SB); end
    end
    f = fall_t.size() ? fall_t[fall_t.size()-1] : 0;
    wait_level(1'b1, 1, 1'b0, 100, tb, ok_b);
    n_vec++; if (ok_b !== 1'b1 || tb - f !== (SB - S1) + SR) begin n_err++;
      $display("FAIL small_latch: got %0d want %0d", tb - f, (SB - S1) + SR); end
  endtask

  initial begin
    pif.pix_valid   = 1'b0;
    pif.pix_data    = '0;
    pif.pix_last    = 1'b0;
    pif_s.pix_valid = 1'b0;
    pif_s.pix_data  = '0;
    pif_s.pix_last  = 1'b0;
    glitch          = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_underrun();
    test_hold_bit12();
    test_small_params();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: got timeout at cycle %0d, want finish before 90000", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/neopixel_tx.md
NEOPIXEL_TX -- requirements
Module: neopixel_tx

Interface
REQ-001 SHALL have parameter T_BIT, default 125: clock cycles per serial bit (1.25 us at 100 MHz).
REQ-002 SHALL have parameter T0H, default 40: high-time cycles for a '0' bit.
REQ-003 SHALL have parameter T1H, default 80: high-time cycles for a '1' bit.
REQ-004 SHALL have parameter T_RST, default 5000: low-time cycles of the end-of-frame latch (50 us).
REQ-005 SHALL have port ACLK, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port ARESET, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port pix_data, input, 24: GRB pixel word from the AXI4-Lite register stage; bit 23 is G7.
REQ-008 SHALL have port pix_last, input, 1: qualifies pix_data as the final pixel of a frame.
REQ-009 SHALL have port pix_valid, input, 1: the upstream pixel word is valid.
REQ-010 SHALL have port pix_ready, output, 1: the block accepts a word this cycle.
REQ-011 SHALL have port dout, output, 1: WS2812 serial line.
REQ-012 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-013 SHALL have port underrun, output, 1: one-cycle pulse when a mid-frame pixel is missing.

Function
REQ-014 SHALL use states IDLE, HIGH, LOW, LATCH.
REQ-015 SHALL complete a transfer on any cycle with pix_valid and pix_ready both high; pix_data/pix_last are captured into a 24-bit shift register and a last flag on that edge.
REQ-016 SHALL assert pix_ready in IDLE, and in LOW only on the final cycle of bit 0 when the last flag is clear; otherwise deassert it.
REQ-017 SHALL, on acceptance, enter HIGH on the next cycle with dout=1, bit index 23, cycle counter 0 (latency acceptance to dout rise: 1 cycle).
REQ-018 SHALL hold HIGH for T1H cycles if the current bit is 1, else T0H cycles, then enter LOW with dout=0.
REQ-019 SHALL hold LOW so that HIGH+LOW equals exactly T_BIT cycles per bit.
REQ-020 SHALL transmit MSB first; at end of LOW with bit index >0, decrement the index and re-enter HIGH.
REQ-021 SHALL, at end of LOW of bit 0: accept a new word and enter HIGH with zero gap if a transfer completes; enter LATCH if the last flag is set; otherwise pulse underrun and enter LATCH.
REQ-022 SHALL hold dout=0 in LATCH for T_RST cycles, then enter IDLE.
REQ-023 SHALL ignore pix_valid whenever pix_ready is low; upstream holds data stable until the transfer.
REQ-024 SHALL use one down/up counter sized to max(T_BIT, T_RST), wrapping never; counter resets to 0 on each state entry.
REQ-025 SHALL register dout, pix_ready, busy and underrun (no combinational paths from inputs to outputs).
REQ-026 SHALL flag at elaboration any parameter set violating 0 < T0H < T1H < T_BIT.

Reset
REQ-027 SHALL, while ARESET is high at a clock edge, force state IDLE, dout=0, pix_ready=0, busy=0, underrun=0, counter=0, shift register=0.
REQ-028 SHALL drive pix_ready=1 on the first cycle after ARESET deasserts.
REQ-029 SHALL abort any frame in progress on reset with dout low from the next edge; no partial bit completion.

Structure
REQ-030 SHALL take the state enumeration and default timing constants from shared package neopixel_pkg.
REQ-031 SHALL be a single module with no sub-modules; the bit/latch timer is inline.

Verification
REQ-032 SHALL check reset: ARESET high 5 cycles mid-bit -> dout=0, busy=0 next edge; pix_ready=1 first cycle after release.
REQ-033 SHALL check single pixel 0xAA0055, pix_last=1 -> 24 bits, each 125 cycles; '1' highs 80 cycles, '0' highs 40 cycles; then 5000 low cycles; busy falls after that.
REQ-034 SHALL check back-to-back 0xFFFFFF then 0x000000 (last) with pix_valid held -> second pixel's first rise exactly 125 cycles after the 24th bit's rise of the first; no gap.
REQ-035 SHALL check underrun: pixel 0x123456, pix_last=0, pix_valid then low -> underrun pulse one cycle at end of bit 0, LATCH 5000 cycles, IDLE.
REQ-036 SHALL check pix_valid asserted during HIGH of bit 12 -> no acceptance until the bit-0 ready cycle; data unchanged.
REQ-037 SHALL check parameters T_BIT=10, T0H=3, T1H=7, T_RST=20 on pixel 0x800001 -> bit 23 high 7, bits 22..1 high 3, bit 0 high 7; 20-cycle latch.
